// File: rtl/chng_gen.sv
// Run-length waveform generator: queued run lengths drive a toggling sig with chngd_sig markers.
// Optional build macro CHNG_GEN_REPEAT_EN: repeat the last run length instead of underrunning.
module chng_gen #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [CNT_W-1:0]         run_len,
    input  logic                     run_valid,
    output logic                     run_ready,
    output logic                     sig,
    output logic                     chngd_sig,
    output logic                     busy,
    output logic                     urun,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] head_len;
    logic             push;
    logic             pop;
    logic             run_end;
    logic             fifo_nempty;
`ifdef CHNG_GEN_REPEAT_EN
    logic [CNT_W-1:0] last_len;
`else
    logic             urun_q;
`endif

    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    assign run_ready   = (fill != FULL_LVL);
    assign fifo_nempty = (fill != '0);
    assign push        = run_valid && run_ready;
    assign run_end     = (state == RUN) && (cnt == CNT_W'(1));
    // A pop happens either to start from IDLE or to chain at a run boundary.
    assign pop         = en && fifo_nempty && ((state == IDLE) || run_end);
    assign head_len    = clamp_len(mem[rd_ptr]);
    assign busy        = (state == RUN);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= run_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

`ifdef CHNG_GEN_REPEAT_EN
    always_ff @(posedge clk) begin
        if (pop) begin
            last_len <= head_len;
        end
    end

    assign urun = 1'b0;
`else
    assign urun = urun_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sig       <= 1'b0;
            chngd_sig <= 1'b0;
`ifndef CHNG_GEN_REPEAT_EN
            urun_q    <= 1'b0;
`endif
        end else begin
            chngd_sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cnt   <= head_len;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (run_end) begin
                        sig       <= !sig;
                        chngd_sig <= 1'b1;
                        if (pop) begin
                            cnt <= head_len;
                        end else if (en) begin
`ifdef CHNG_GEN_REPEAT_EN
                            cnt <= last_len;
`else
                            urun_q <= 1'b1;
                            state  <= IDLE;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chng_gen.sv
// Self-checking bench for chng_gen: directed test-plan sequences plus random traffic
// checked every cycle against a timestamp/queue reference model.
module tb_chng_gen;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [CNT_W-1:0]       run_len;
    logic                   run_valid;
    logic                   run_ready;
    logic                   sig;
    logic                   chngd_sig;
    logic                   busy;
    logic                   urun;
    logic [$clog2(DEPTH):0] fill;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queued lengths and the absolute cycle of the next toggle.
    int q[$];
    bit m_sig, m_chng, m_run, m_urun;
    int m_next, m_last, tcyc;

    always #5 clk = ~clk;

    chng_gen #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .run_len   (run_len),
        .run_valid (run_valid),
        .run_ready (run_ready),
        .sig       (sig),
        .chngd_sig (chngd_sig),
        .busy      (busy),
        .urun      (urun),
        .fill      (fill)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sig  = 1'b0;
        m_chng = 1'b0;
        m_run  = 1'b0;
        m_urun = 1'b0;
    endtask

    task automatic model_take();
        int l;
        l = q.pop_front();
        if (l == 0) l = 1;
        m_last = l;
        m_next = tcyc + l;
        m_run  = 1'b1;
    endtask

    task automatic model_step();
        bit do_push;
        int pv;
        do_push = run_valid && (q.size() < DEPTH);
        pv      = int'(run_len);
        tcyc++;
        m_chng = 1'b0;
        if (m_run) begin
            if (tcyc == m_next) begin
                m_sig  = !m_sig;
                m_chng = 1'b1;
                if (en && q.size() > 0) begin
                    model_take();
                end else if (en) begin
`ifdef CHNG_GEN_REPEAT_EN
                    m_next = tcyc + m_last;
`else
                    m_urun = 1'b1;
                    m_run  = 1'b0;
`endif
                end else begin
                    m_run = 1'b0;
                end
            end
        end else if (en && q.size() > 0) begin
            model_take();
        end
        if (do_push) q.push_back(pv);
    endtask

    task automatic check_all();
        chk("sig", sig, m_sig);
        chk("chngd_sig", chngd_sig, m_chng);
        chk("busy", busy, m_run);
        chk("urun", urun, m_urun);
        chk("fill", fill, q.size());
        chk("run_ready", run_ready, q.size() < DEPTH);
    endtask

    task automatic cycle(input bit v, input int len, input bit e);
        run_valid = v;
        run_len   = CNT_W'(len);
        en        = e;
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < n; i++) begin
            run_valid = 1'($urandom);
            run_len   = CNT_W'($urandom);
            en        = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
    endtask

    initial begin
        logic exp_basic [9];
        int   pulses;
        bit   e_rand;
        int   len;

        rst = 1'b0; en = 1'b0; run_valid = 1'b0; run_len = '0; tcyc = 0;
        model_reset();
        @(negedge clk);

        // Reset held with random inputs
        do_reset(3);

        // Basic sequence 2,3,2
        do_reset(1);
        cycle(1, 2, 0); cycle(1, 3, 0); cycle(1, 2, 0);
        exp_basic = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1);
            chk("basic_sig", sig, exp_basic[i]);
            pulses += int'(chngd_sig);
        end
        chk("basic_pulses", pulses, 3);
`ifndef CHNG_GEN_REPEAT_EN
        chk("basic_busy", busy, 0);
        chk("basic_urun", urun, 1);
`endif

        // Full FIFO
        do_reset(1);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0);
        chk("full_fill", fill, 4);
        chk("full_ready", run_ready, 0);
        cycle(0, 0, 1);
        chk("pop_fill", fill, 3);
        chk("pop_ready", run_ready, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1);

        // Zero lengths
        do_reset(1);
        cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
        cycle(0, 0, 1);
        chk("zero_start_sig", sig, 0);
        chk("zero_start_chg", chngd_sig, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            chk("zero_sig", sig, (i % 2 == 0) ? 1 : 0);
            chk("zero_chg", chngd_sig, 1);
        end
        cycle(0, 0, 1);
`ifndef CHNG_GEN_REPEAT_EN
        chk("zero_end_chg", chngd_sig, 0);
`endif

        // Reset in the middle of a run
        do_reset(1);
        cycle(1, 3, 0); cycle(1, 10, 0); cycle(1, 5, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1);
        chk("pre_rst_sig", sig, 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_sig", sig, 0);
        chk("mid_rst_fill", fill, 0);
        @(negedge clk);
        check_all();
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle(0, 0, 1);
            chk("post_rst_sig", sig, 0);
        end

        // Random traffic
        do_reset(1);
        e_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) e_rand = !e_rand;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
            if (i == 400) do_reset(2);
            cycle(1'($urandom_range(0, 1)), len, e_rand);
        end

`ifdef CHNG_GEN_REPEAT_EN
        // Periodic repeat of a single run length
        do_reset(1);
        cycle(1, 4, 1);
        pulses = 0;
        for (int i = 0; i < 44; i++) begin
            cycle(0, 0, 1);
            pulses += int'(chngd_sig);
        end
        chk("rep_toggles", pulses, 10);
        chk("rep_urun", urun, 0);
        cycle(1, 2, 1);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
